// File: rtl/ddr3_clkdiv_rst_seq.sv
// ddr3_clkdiv_rst_seq
// Reset/calibration sequencer for the DDR3 divide-by-5 CLKDIV stage.
// Filters the PLL lock, holds CLKDIV in reset until the lock is stable,
// releases it, waits a settle time and then flags the divided clock ready.
// Issues CALIB pulses on request while ready. Any loss of lock restarts
// the whole sequence and is counted.
//
// Ports:
//   clk            sequencer clock (PLL reference domain)
//   rst            synchronous active-high reset
//   pll_lock       PLL lock, asynchronous to clk
//   calib_req      request one CALIB pulse (honoured only when ready)
//   clkdiv_resetn  CLKDIV RESETN, active-low
//   clkdiv_calib   CLKDIV CALIB
//   ready          divided clock stable and usable
//   relock_cnt     saturating count of lock-loss events since rst
module ddr3_clkdiv_rst_seq #(
  parameter int unsigned LOCK_FILTER = 16,
  parameter int unsigned RESET_HOLD  = 32,
  parameter int unsigned SETTLE      = 64,
  parameter int unsigned CALIB_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       calib_req,
  output logic       clkdiv_resetn,
  output logic       clkdiv_calib,
  output logic       ready,
  output logic [7:0] relock_cnt
);

  localparam int unsigned MAX_A = (LOCK_FILTER > RESET_HOLD) ? LOCK_FILTER : RESET_HOLD;
  localparam int unsigned MAX_B = (SETTLE > CALIB_W) ? SETTLE : CALIB_W;
  localparam int unsigned MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W = $clog2(MAX_P + 1);

  localparam logic [CNT_W-1:0] FILT_LAST   = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CALIB_LAST  = CNT_W'(CALIB_W - 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_HOLD      = 3'd1,
    S_SETTLE    = 3'd2,
    S_READY     = 3'd3,
    S_CALIB     = 3'd4
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sync1_q;
  logic             lock_s_q;
  logic             resetn_q;
  logic             calib_q;
  logic             ready_q;
  logic [7:0]       relock_q;

  // Sequencer: one shared phase counter, cleared on every state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_WAIT_LOCK;
      cnt_q    <= '0;
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
      resetn_q <= 1'b0;
      calib_q  <= 1'b0;
      ready_q  <= 1'b0;
      relock_q <= 8'd0;
    end else begin
      sync1_q  <= pll_lock;
      lock_s_q <= sync1_q;

      if (state_q == S_WAIT_LOCK) begin
        // A low lock_s here is only a filter restart, never a relock event.
        if (!lock_s_q) begin
          cnt_q <= '0;
        end else if (cnt_q == FILT_LAST) begin
          state_q <= S_HOLD;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else if (!lock_s_q) begin
        // Lock loss wins over calib_req and any same-cycle phase exit.
        state_q  <= S_WAIT_LOCK;
        cnt_q    <= '0;
        resetn_q <= 1'b0;
        calib_q  <= 1'b0;
        ready_q  <= 1'b0;
        if (relock_q != 8'hFF) begin
          relock_q <= relock_q + 8'd1;
        end
      end else begin
        case (state_q)
          S_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
              state_q  <= S_SETTLE;
              cnt_q    <= '0;
              resetn_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
              state_q <= S_READY;
              cnt_q   <= '0;
              ready_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_READY: begin
            if (calib_req) begin
              state_q <= S_CALIB;
              cnt_q   <= '0;
              calib_q <= 1'b1;
              ready_q <= 1'b0;
            end
          end
          S_CALIB: begin
            if (cnt_q == CALIB_LAST) begin
              state_q <= S_READY;
              cnt_q   <= '0;
              calib_q <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            // Illegal encoding: fall back to a safe restart.
            state_q  <= S_WAIT_LOCK;
            cnt_q    <= '0;
            resetn_q <= 1'b0;
            calib_q  <= 1'b0;
            ready_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign clkdiv_resetn = resetn_q;
  assign clkdiv_calib  = calib_q;
  assign ready         = ready_q;
  assign relock_cnt    = relock_q;

endmodule

// File: doc/ddr3_clkdiv_rst_seq.md
Name: ddr3_clkdiv_rst_seq

Overview:
Reset/calibration sequencer directly upstream of the DDR3 divide-by-5 CLKDIV stage. Watches the PLL lock, filters it, and holds the CLKDIV resetn low until lock is stable. It then releases resetn and waits a settle period before declaring the divided clock usable. It also issues on-demand CALIB pulses and restarts the whole sequence on any loss of lock.

Parameters:
LOCK_FILTER, 16, consecutive synchronized-lock-high cycles required before leaving WAIT_LOCK (>=1)
RESET_HOLD, 32, cycles clkdiv_resetn stays low in HOLD after lock qualifies (>=1)
SETTLE, 64, cycles after resetn release before ready asserts (>=1)
CALIB_W, 4, width in cycles of each clkdiv_calib pulse (>=1)

Ports:
clk  input  1  free-running sequencer clock (PLL reference domain)
rst  input  1  synchronous, active-high reset
pll_lock  input  1  PLL lock, asynchronous to clk
calib_req  input  1  request one CALIB pulse; honoured only in READY
clkdiv_resetn  output  1  drives CLKDIV RESETN, active-low
clkdiv_calib  output  1  drives CLKDIV CALIB
ready  output  1  divided clock stable and usable downstream
relock_cnt  output  8  saturating count of lock-loss events since rst

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). All outputs registered.
- Reset values: clkdiv_resetn=0, clkdiv_calib=0, ready=0, relock_cnt=0, state=WAIT_LOCK, all counters 0, synchronizer flops 0.
- pll_lock passes through a 2-flop synchronizer; lock_s is the second flop. Only lock_s is used internally.
- Counter widths: $clog2(max parameter + 1). Each counter resets to 0 on every state entry.
- States:
  - WAIT_LOCK: the filter counter increments while lock_s=1 and clears to 0 on any lock_s=0. At count==LOCK_FILTER-1 with lock_s=1, go to HOLD. Outputs: resetn=0, calib=0, ready=0.
  - HOLD: resetn=0. Stay exactly RESET_HOLD cycles, then go to SETTLE.
  - SETTLE: resetn=1. Stay exactly SETTLE cycles, then go to READY.
  - READY: resetn=1, ready=1. calib_req=1 goes to CALIB.
  - CALIB: resetn=1, ready=0, calib=1 for exactly CALIB_W cycles, then back to READY.
- Timing: let t be the first cycle lock_s=1, with lock held. State=HOLD at t+LOCK_FILTER. clkdiv_resetn=1 at t+LOCK_FILTER+RESET_HOLD. ready=1 at t+LOCK_FILTER+RESET_HOLD+SETTLE.
- In CALIB, clkdiv_calib=1 from the cycle after calib_req is sampled in READY. ready=1 again on the cycle calib falls.
- calib_req in any state other than READY is ignored and not queued. A calib_req held high through CALIB triggers another pulse immediately on return to READY, one cycle of ready=1 between pulses.
- Lock loss: lock_s=0 in HOLD, SETTLE, READY or CALIB causes the following on the next edge:
  - state goes to WAIT_LOCK;
  - resetn=0, calib=0, ready=0;
  - relock_cnt increments, saturating at 255.
  Lock loss takes priority over calib_req and over any same-cycle state-exit transition.
- Glitch rule: a lock_s low pulse during WAIT_LOCK only restarts the filter. It does not count as a relock.
- Reset mid-sequence: rst returns everything to reset values on the next edge, including relock_cnt. rst has priority over everything.

Test Plan:
- Power-up, defaults: rst high 5 cycles, then pll_lock=1 held -> clkdiv_resetn rises 2+16+32=50 cycles after pll_lock first sampled high; ready rises 64 cycles later; relock_cnt=0.
- Lock glitch in filter: pll_lock drops 1 cycle when filter count=10 -> filter restarts; resetn rise delayed by the glitch offset; relock_cnt stays 0.
- Calibration: in READY, pulse calib_req 1 cycle -> clkdiv_calib high exactly 4 cycles starting the next cycle; ready low those 4 cycles; resetn stays 1.
- Lock loss in READY: pll_lock low 3 cycles -> resetn=0 and ready=0 within 3 cycles of the pll_lock fall (2-flop sync + 1 edge); relock_cnt=1; full 16/32/64 sequence replays after lock returns.
- Lock loss during CALIB concurrent with calib_req -> calib=0, state WAIT_LOCK, no further pulse; relock_cnt saturation: 300 loss events leave relock_cnt=255.
- rst asserted in SETTLE -> all outputs at reset values next cycle; sequence restarts from WAIT_LOCK after rst release.
